// File: rtl/rf_ctrl_pkg.sv
// Shared definitions for the register-file write scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: scheduler state encoding, the non-writable PC register index,
// and default parameter values.
package rf_ctrl_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } sched_state_e;

  // R15 reads as PC+8 and has no storage behind it.
  localparam logic [3:0] REG_PC = 4'd15;

  localparam int DEF_W            = 32;
  localparam int DEF_NCLR         = 15;
  localparam int DEF_STARVE_LIMIT = 4;

endpackage

// File: rtl/rf_wr_prio_arbiter.sv
// Two-way priority arbiter for the register-file write port, with anti-starvation for REQ1.
// Latency: grants are combinational; only the starvation counter is registered.
// Backpressure: a requester without a grant keeps VALID asserted; EN=0 suppresses all grants.
// Ports: CLK, RESET (async active-low), EN (arbitration allowed),
//        REQ0_VALID / REQ1_VALID in, GNT0 / GNT1 out (one-hot or zero).
module rf_wr_prio_arbiter
  import rf_ctrl_pkg::*;
#(
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic CLK,
  input  logic RESET,
  input  logic EN,
  input  logic REQ0_VALID,
  input  logic REQ1_VALID,
  output logic GNT0,
  output logic GNT1
);

  localparam int              CW  = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0]   LIM = CW'(STARVE_LIMIT);

  logic [CW-1:0] starve_cnt_q;
  logic [CW-1:0] starve_cnt_d;
  logic          req1_starved;

  always_comb begin
    // REQ0 normally wins; once REQ1 has lost LIM times in a row it is served next.
    req1_starved = REQ1_VALID && (starve_cnt_q == LIM);
    GNT0         = EN && REQ0_VALID && !req1_starved;
    GNT1         = EN && REQ1_VALID && !GNT0;

    starve_cnt_d = starve_cnt_q;
    if (!REQ1_VALID || GNT1) begin
      starve_cnt_d = '0;
    end else if (GNT0 && (starve_cnt_q != LIM)) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: rtl/rf_write_scheduler.sv
// Owns the register-file write port: clears R0..NCLR-1 after reset, then arbitrates load vs ALU writeback.
// Latency: one cycle from an accepted request to WE3/A3/WD3; one write per cycle, no buffering.
// Backpressure: READY is low during the clear and for the arbitration loser; requesters hold until READY.
// Ports: CLK, RESET (async active-low); REQ0_*/REQ1_* valid-ready requesters;
//        A3/WD3/WE3 registered register-file write port; BUSY (clear running); DROP (R15 write discarded).
module rf_write_scheduler
  import rf_ctrl_pkg::*;
#(
  parameter int W            = DEF_W,
  parameter int NCLR         = DEF_NCLR,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         REQ0_VALID,
  input  logic [3:0]   REQ0_ADDR,
  input  logic [W-1:0] REQ0_DATA,
  output logic         REQ0_READY,
  input  logic         REQ1_VALID,
  input  logic [3:0]   REQ1_ADDR,
  input  logic [W-1:0] REQ1_DATA,
  output logic         REQ1_READY,
  output logic [3:0]   A3,
  output logic [W-1:0] WD3,
  output logic         WE3,
  output logic         BUSY,
  output logic         DROP
);

  localparam logic [3:0] CLR_LAST = 4'(NCLR - 1);

  sched_state_e state_q, state_d;
  logic [3:0]   clr_cnt_q, clr_cnt_d;
  logic         we3_q, we3_d;
  logic [3:0]   a3_q, a3_d;
  logic [W-1:0] wd3_q, wd3_d;
  logic         drop_q, drop_d;

  logic         gnt0;
  logic         gnt1;
  logic [3:0]   sel_addr;
  logic [W-1:0] sel_data;

  rf_wr_prio_arbiter #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_arb (
    .CLK        (CLK),
    .RESET      (RESET),
    .EN         (state_q == ST_RUN),
    .REQ0_VALID (REQ0_VALID),
    .REQ1_VALID (REQ1_VALID),
    .GNT0       (gnt0),
    .GNT1       (gnt1)
  );

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    we3_d     = 1'b0;
    a3_d      = a3_q;
    wd3_d     = wd3_q;
    drop_d    = 1'b0;

    sel_addr  = gnt0 ? REQ0_ADDR : REQ1_ADDR;
    sel_data  = gnt0 ? REQ0_DATA : REQ1_DATA;

    unique case (state_q)
      ST_CLEAR: begin
        we3_d     = 1'b1;
        a3_d      = clr_cnt_q;
        wd3_d     = '0;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == CLR_LAST) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (gnt0 || gnt1) begin
          if (sel_addr == REG_PC) begin
            // Accepted but discarded; the write port keeps its last address/data.
            drop_d = 1'b1;
          end else begin
            we3_d = 1'b1;
            a3_d  = sel_addr;
            wd3_d = sel_data;
          end
        end
      end
      default: begin
        state_d = ST_CLEAR;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
      we3_q     <= 1'b0;
      a3_q      <= '0;
      wd3_q     <= '0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      we3_q     <= we3_d;
      a3_q      <= a3_d;
      wd3_q     <= wd3_d;
      drop_q    <= drop_d;
    end
  end

  assign REQ0_READY = gnt0;
  assign REQ1_READY = gnt1;
  assign WE3        = we3_q;
  assign A3         = a3_q;
  assign WD3        = wd3_q;
  assign DROP       = drop_q;
  assign BUSY       = (state_q == ST_CLEAR);

endmodule

// File: doc/rf_write_scheduler.md
Name: rf_write_scheduler

Overview:
Sequences and arbitrates the single register-file write port (A3/WD3/WE3) between two writeback requesters: REQ0 (memory/load) and REQ1 (ALU).
After reset it runs a clear sequence that writes zero to R0..R14 before accepting any request.
Requests that target R15 (PC+8, not writable) are consumed and dropped.
It sits between the writeback stage and the register file; its outputs drive the register file write inputs directly.

Parameters:
W, 32, data width of WD3 and request data
NCLR, 15, number of registers cleared after reset (R0..NCLR-1)
STARVE_LIMIT, 4, consecutive lost arbitrations after which REQ1 gets priority

Ports:
CLK  in  1  clock; all state updates on the rising edge
RESET  in  1  asynchronous, active-low reset
REQ0_VALID  in  1  load writeback request
REQ0_ADDR  in  4  destination register
REQ0_DATA  in  W  write data
REQ0_READY  out  1  REQ0 accepted this cycle
REQ1_VALID  in  1  ALU writeback request
REQ1_ADDR  in  4  destination register
REQ1_DATA  in  W  write data
REQ1_READY  out  1  REQ1 accepted this cycle
A3  out  4  register file write address (registered)
WD3  out  W  register file write data (registered)
WE3  out  1  register file write enable (registered)
BUSY  out  1  high while the clear sequence runs
DROP  out  1  one-cycle pulse: an accepted request targeted R15

Behaviour:
- Reset (RESET=0, asynchronous):
  - state=CLEAR, clr_cnt=0, starve_cnt=0.
  - WE3=0, A3=0, WD3=0, DROP=0, BUSY=1.
  - REQ0_READY=REQ1_READY=0.
- Reset asserted at any time, including mid-clear or mid-write, aborts the operation. Unaccepted requests are simply not acknowledged.
- State CLEAR:
  - Each cycle registers WE3=1, A3=clr_cnt, WD3=0, then increments clr_cnt.
  - When clr_cnt=NCLR-1 is issued, the next state is RUN.
  - First edge after reset release gives A3=0; edge NCLR gives A3=NCLR-1.
  - BUSY falls on the same edge the state enters RUN.
  - Both READY outputs are 0 throughout CLEAR.
- State RUN:
  - READY outputs are combinational from VALID, state and starve_cnt; at most one READY is high per cycle.
  - Handshake: a transfer occurs when VALID&&READY. The requester must hold VALID/ADDR/DATA stable until READY.
  - Priority: REQ0 is granted when REQ0_VALID and not (REQ1_VALID and starve_cnt==STARVE_LIMIT). Otherwise REQ1 is granted when REQ1_VALID.
- Starvation counter:
  - starve_cnt increments (saturating at STARVE_LIMIT) when REQ1_VALID is high and REQ0 is granted.
  - It clears when REQ1 is granted or REQ1_VALID is 0.
- Write issue, latency 1:
  - On the edge after a transfer with ADDR!=15: WE3=1, A3=ADDR, WD3=DATA.
  - With no transfer: WE3=0, and A3/WD3 hold their last values.
- R15 drop:
  - A transfer with ADDR==15 is accepted (READY=1) with WE3=0 next cycle and DROP=1 for one cycle.
- Same-address simultaneous requests: only the granted one writes. The loser writes in a later cycle, so the last write wins in grant order.
- Throughput: one write per cycle. No internal buffering.

Decomposition:
- Shared package rf_ctrl_pkg holds:
  - state encoding (CLEAR=1'b0, RUN=1'b1)
  - REG_PC=4'd15
  - default W/NCLR/STARVE_LIMIT constants
- One sub-module, rf_wr_prio_arbiter:
  - combinational grant logic plus starve_cnt register (CLK/RESET)
  - outputs GNT0/GNT1
  - the top level holds the CLEAR/RUN FSM and the output registers.

Test Plan:
- Reset release, no requests -> WE3=1 on 15 consecutive edges with A3=0..14, WD3=0, BUSY=1; then WE3=0, BUSY=0, READY outputs follow VALID.
- After clear, REQ1 VALID ADDR=3 DATA=0xDEADBEEF -> REQ1_READY=1 same cycle; next edge WE3=1, A3=3, WD3=0xDEADBEEF; following edge WE3=0.
- Both VALID same cycle (REQ0 ADDR=5 DATA=0x11, REQ1 ADDR=5 DATA=0x22) -> REQ0 granted first (A3=5, WD3=0x11), REQ1 next cycle (WD3=0x22).
- REQ0 VALID every cycle, REQ1 VALID held -> REQ0 granted 4 cycles, REQ1 granted on the 5th, starve_cnt returns to 0, REQ0 resumes.
- REQ0 VALID ADDR=15 DATA=0x1234 -> REQ0_READY=1; next edge WE3=0, DROP=1 for exactly one cycle.
- RESET pulsed low during clear at A3=7, and again during a RUN write -> WE3=0 immediately (asynchronous); after release the clear restarts at A3=0.
